// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF measurement path.
package puf_pkg;

    // Measurement sequencer states; encoding is fixed so it can be probed directly.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Flops used to bring each raw oscillator output into the clk domain.
    localparam int SYNC_STAGES = 2;

    // Ceiling log2 for sizing counters from elaboration-time parameters.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// One measurement channel: synchronizer, rising-edge detector and saturating edge counter.
module ro_edge_counter
    import puf_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int STAGES = SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             ro_raw,
    output logic [CNT_W-1:0] cnt
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rise;

    // A rising edge is a 0 -> 1 step between the last sync stage and the edge-detect flop.
    assign rise = sync_q[STAGES-1] & ~prev_q;

    // Next state: shift the synchronizer, track the previous level, count edges without wrapping.
    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
        sync_d = {sync_q[STAGES-2:0], ro_raw};
        prev_d = sync_q[STAGES-1];
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && rise && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Channel registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the synchronizer flops are reset too, so a fresh measurement never sees a stale level as an edge.
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample its pre-edge input, as real hardware does.
            sync_q <= sync_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ro_pair_comparator.sv
// RO-PUF measurement end: enables a challenged oscillator pair, counts both over a fixed window,
// and reports which one ran faster together with both counts.
module ro_pair_comparator
    import puf_pkg::*;
#(
    parameter int N_RO   = 8,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1024,
    parameter int SETTLE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_RO-1:0]  ro_in,
    output logic [N_RO-1:0]  ro_en,
    input  logic             start,
    input  logic [SEL_W-1:0] chal_a,
    input  logic [SEL_W-1:0] chal_b,
    output logic             busy,
    output logic             done,
    output logic             resp,
    output logic             tie,
    output logic             err,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    // One down-counter times both phases, so it is sized for the longer of the two.
    localparam int SPAN  = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W = clog2(SPAN) + 1;
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [SEL_W-1:0] idx_a_q, idx_a_d;
    logic [SEL_W-1:0] idx_b_q, idx_b_d;
    logic [N_RO-1:0]  ro_en_q, ro_en_d;
    logic             err_q, err_d;
    logic             show_q, show_d;
    logic             chal_ok;
    logic             clr;
    logic             count_en;
    logic             raw_a, raw_b;
    logic [CNT_W-1:0] edge_cnt_a, edge_cnt_b;

    // A challenge is usable only if it names two different oscillators that exist.
    assign chal_ok = (chal_a != chal_b) && (int'(chal_a) < N_RO) && (int'(chal_b) < N_RO);

    // Route the two latched oscillators to the counting channels.
    always_comb begin
        raw_a = 1'b0;
        raw_b = 1'b0;
        for (int i = 0; i < N_RO; i++) begin
            if (int'(idx_a_q) == i) raw_a = ro_in[i];
            if (int'(idx_b_q) == i) raw_b = ro_in[i];
        end
    end

    assign count_en = (state_q == ST_COUNT);

    ro_edge_counter #(.CNT_W(CNT_W), .STAGES(SYNC_STAGES)) u_cnt_a (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (count_en),
        .ro_raw (raw_a),
        .cnt    (edge_cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W), .STAGES(SYNC_STAGES)) u_cnt_b (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (count_en),
        .ro_raw (raw_b),
        .cnt    (edge_cnt_b)
    );

    // Sequencer: accept and validate a challenge, time settle and window, then show results.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_a_d = idx_a_q;
        idx_b_d = idx_b_q;
        err_d   = err_q;
        show_d  = show_q;
        clr     = 1'b0;
        ro_en_d = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr    = 1'b1;
                    show_d = 1'b0;
                    if (chal_ok) begin
                        idx_a_d = chal_a;
                        idx_b_d = chal_b;
                        err_d   = 1'b0;
                        tmr_d   = SETTLE_LOAD;
                        state_d = ST_SETTLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_q == '0) begin
                    tmr_d   = WINDOW_LOAD;
                    state_d = ST_COUNT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_COUNT: begin
                if (tmr_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Results become visible on entry to DONE and stay until the next accept clears them.
        if (state_d == ST_DONE) show_d = 1'b1;

        // The pair is powered only while settling and counting.
        if ((state_d == ST_SETTLE) || (state_d == ST_COUNT)) begin
            for (int i = 0; i < N_RO; i++) begin
                ro_en_d[i] = (int'(idx_a_d) == i) || (int'(idx_b_d) == i);
            end
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            idx_a_q <= '0;
            idx_b_q <= '0;
            ro_en_q <= '0;
            err_q   <= 1'b0;
            show_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_a_q <= idx_a_d;
            idx_b_q <= idx_b_d;
            ro_en_q <= ro_en_d;
            err_q   <= err_d;
            show_q  <= show_d;
        end
    end

    // Counters are frozen once the window closes, so the comparison is taken straight from them.
    assign ro_en = ro_en_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign err   = err_q;
    assign cnt_a = show_q ? edge_cnt_a : '0;
    assign cnt_b = show_q ? edge_cnt_b : '0;
    assign resp  = show_q & ~err_q & (edge_cnt_a > edge_cnt_b);
    assign tie   = show_q & ~err_q & (edge_cnt_a == edge_cnt_b);

endmodule

// File: tb/tb_ro_pair_comparator.sv
// Bench for ro_pair_comparator: three instances (8 ROs, 6 ROs, 4-bit counters) share
// clk/rst/start/challenge; each has its own gated behavioural oscillator bank.
module tb_ro_pair_comparator;

    localparam int WIN = 64;
    localparam int STL = 4;
    localparam int LAT = 1 + STL + WIN;
    localparam int CLK_HALF = 10;

    // Oscillator half periods in 2-time-unit ticks (10 ticks per clk); 0 = never toggles.
    localparam int HALF0 [8] = '{14, 26, 20, 30, 30, 40, 50, 16};
    localparam int HALF1 [8] = '{20, 0, 0, 0, 0, 0, 0, 0};
    localparam int HALF2 [8] = '{10, 0, 0, 0, 0, 0, 0, 0};

    typedef struct {
        int         dut;
        logic [2:0] a;
        logic [2:0] b;
        logic [7:0] mask;
        int         lat;
        logic       err;
        logic       resp;
        logic       tie;
        int         cnt_a;
        int         cnt_b;
        int         tol;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [2:0] chal_a, chal_b;

    logic [7:0] ro_lvl [3];
    int         ph [3][8];

    logic [7:0] ro_in0, ro_in2, ro_en0, ro_en2;
    logic [5:0] ro_in1, ro_en1;
    logic busy0, done0, resp0, tie0, err0;
    logic busy1, done1, resp1, tie1, err1;
    logic busy2, done2, resp2, tie2, err2;
    logic [15:0] cnt_a0, cnt_b0, cnt_a1, cnt_b1;
    logic [3:0]  cnt_a2, cnt_b2;

    assign ro_in0 = ro_lvl[0];
    assign ro_in1 = ro_lvl[1][5:0];
    assign ro_in2 = ro_lvl[2];

    always #CLK_HALF clk = ~clk;

    ro_pair_comparator #(.N_RO(8), .SEL_W(3), .CNT_W(16), .WINDOW(WIN), .SETTLE(STL)) dut (
        .clk(clk), .rst(rst), .ro_in(ro_in0), .ro_en(ro_en0), .start(start),
        .chal_a(chal_a), .chal_b(chal_b), .busy(busy0), .done(done0), .resp(resp0),
        .tie(tie0), .err(err0), .cnt_a(cnt_a0), .cnt_b(cnt_b0));

    ro_pair_comparator #(.N_RO(6), .SEL_W(3), .CNT_W(16), .WINDOW(WIN), .SETTLE(STL)) dut6 (
        .clk(clk), .rst(rst), .ro_in(ro_in1), .ro_en(ro_en1), .start(start),
        .chal_a(chal_a), .chal_b(chal_b), .busy(busy1), .done(done1), .resp(resp1),
        .tie(tie1), .err(err1), .cnt_a(cnt_a1), .cnt_b(cnt_b1));

    ro_pair_comparator #(.N_RO(8), .SEL_W(3), .CNT_W(4), .WINDOW(WIN), .SETTLE(STL)) dut4 (
        .clk(clk), .rst(rst), .ro_in(ro_in2), .ro_en(ro_en2), .start(start),
        .chal_a(chal_a), .chal_b(chal_b), .busy(busy2), .done(done2), .resp(resp2),
        .tie(tie2), .err(err2), .cnt_a(cnt_a2), .cnt_b(cnt_b2));

    // Behavioural oscillators: stopped at 0 while disabled, free-running from a fixed phase once enabled.
    initial begin
        for (int d = 0; d < 3; d++) begin
            ro_lvl[d] = 8'h00;
            for (int i = 0; i < 8; i++) ph[d][i] = 0;
        end
        #1;
        forever begin
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < 8; i++) begin
                    logic on;
                    int   h;
                    on = (d == 0) ? ro_en0[i] : (d == 2) ? ro_en2[i] : ((i < 6) ? ro_en1[i] : 1'b0);
                    h  = (d == 0) ? HALF0[i] : (d == 1) ? HALF1[i] : HALF2[i];
                    if (!on || h == 0) begin
                        ro_lvl[d][i] = 1'b0;
                        ph[d][i] = 0;
                    end else begin
                        ph[d][i] = ph[d][i] + 1;
                        if (ph[d][i] == h) begin
                            ro_lvl[d][i] = ~ro_lvl[d][i];
                            ph[d][i] = 0;
                        end
                    end
                end
            end
            #2;
        end
    end

    // Observation mux onto the instance under test.
    int sel = 0;
    logic o_busy, o_done, o_resp, o_tie, o_err;
    logic [15:0] o_cnt_a, o_cnt_b;
    logic [7:0]  o_en;
    always_comb begin
        o_busy = busy0; o_done = done0; o_resp = resp0; o_tie = tie0; o_err = err0;
        o_cnt_a = cnt_a0; o_cnt_b = cnt_b0; o_en = ro_en0;
        if (sel == 1) begin
            o_busy = busy1; o_done = done1; o_resp = resp1; o_tie = tie1; o_err = err1;
            o_cnt_a = cnt_a1; o_cnt_b = cnt_b1; o_en = {2'b00, ro_en1};
        end else if (sel == 2) begin
            o_busy = busy2; o_done = done2; o_resp = resp2; o_tie = tie2; o_err = err2;
            o_cnt_a = {12'h000, cnt_a2}; o_cnt_b = {12'h000, cnt_b2}; o_en = ro_en2;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input longint act, input longint exp, input int tol);
        n_checks++;
        if (act < exp - tol || act > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // Expected edge count for an oscillator enabled at a clk edge: rising edge k lands
    // 2*(2k+1)*half-1 time units later and is counted if it arrives inside the count window
    // shifted back by the two-cycle synchronizer delay.
    function automatic int model_edges(input int half_ticks);
        int n;
        n = 0;
        if (half_ticks == 0) return 0;
        for (int k = 0; k < 1000; k++) begin
            int x;
            x = 2 * (2 * k + 1) * half_ticks - 1;
            if (x >= 2 * CLK_HALF * (STL + WIN - 2)) break;
            if (x >= 2 * CLK_HALF * (STL - 2)) n++;
        end
        return n;
    endfunction

    function automatic vec_t mk(input int d, input logic [2:0] a, input logic [2:0] b,
                                input logic [7:0] mask, input int lat, input logic e,
                                input logic r, input logic t, input int ca, input int cb, input int tol);
        vec_t v;
        v.dut = d; v.a = a; v.b = b; v.mask = mask; v.lat = lat; v.err = e;
        v.resp = r; v.tie = t; v.cnt_a = ca; v.cnt_b = cb; v.tol = tol;
        return v;
    endfunction

    // Issue one challenge, then follow the selected instance until done (bounded).
    task automatic run_one(input int which, input logic [2:0] a, input logic [2:0] b,
                           input logic [7:0] mask, output int lat, output logic en_ok,
                           output logic clr_ok);
        sel = which;
        @(negedge clk);
        start = 1'b1; chal_a = a; chal_b = b;
        @(negedge clk);
        start = 1'b0; chal_a = 3'($urandom); chal_b = 3'($urandom);
        lat = 1; en_ok = 1'b1; clr_ok = 1'b1;
        if (!o_done && (o_cnt_a != 0 || o_cnt_b != 0 || o_resp || o_tie || o_err)) clr_ok = 1'b0;
        while (!o_done && lat < 400) begin
            if (o_en !== mask || o_busy !== 1'b1) en_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (o_en !== 8'h00 || o_busy !== 1'b1) en_ok = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy0 || busy1 || busy2) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("idle_timeout", 1, 0);
    endtask

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic en_ok, clr_ok;

        vecs[0] = mk(0, 3'd2, 3'd5, 8'b0010_0100, LAT, 1'b0, 1'b1, 1'b0, 16, 8, 1);
        vecs[1] = mk(0, 3'd5, 3'd2, 8'b0010_0100, LAT, 1'b0, 1'b0, 1'b0, 8, 16, 1);
        vecs[2] = mk(0, 3'd3, 3'd4, 8'b0001_1000, LAT, 1'b0, 1'b0, 1'b1, 11, 11, 1);
        vecs[3] = mk(0, 3'd6, 3'd6, 8'b0000_0000, 1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        vecs[4] = mk(1, 3'd1, 3'd7, 8'b0000_0000, 1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        vecs[5] = mk(1, 3'd6, 3'd0, 8'b0000_0000, 1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        vecs[6] = mk(2, 3'd0, 3'd1, 8'b0000_0011, LAT, 1'b0, 1'b1, 1'b0, 15, 0, 0);
        vecs[7] = mk(0, 3'd7, 3'd0, 8'b1000_0001, LAT, 1'b0, 1'b0, 1'b0, 20, 23, 1);

        rst = 1'b1; start = 1'b0; chal_a = 3'd0; chal_b = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_ro_en", ro_en0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_resp_tie_err", {resp0, tie0, err0}, 0);
        check("rst_cnt_a", cnt_a0, 0);
        check("rst_cnt_b", cnt_b0, 0);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_one(vecs[i].dut, vecs[i].a, vecs[i].b, vecs[i].mask, lat, en_ok, clr_ok);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_ro_en_busy", i), en_ok, 1);
            if (vecs[i].lat > 1) check($sformatf("vec%0d_cleared_on_accept", i), clr_ok, 1);
            check($sformatf("vec%0d_err", i), o_err, vecs[i].err);
            check($sformatf("vec%0d_resp", i), o_resp, vecs[i].resp);
            check($sformatf("vec%0d_tie", i), o_tie, vecs[i].tie);
            check_near($sformatf("vec%0d_cnt_a", i), o_cnt_a, vecs[i].cnt_a, vecs[i].tol);
            check_near($sformatf("vec%0d_cnt_b", i), o_cnt_b, vecs[i].cnt_b, vecs[i].tol);
            @(negedge clk);
            check($sformatf("vec%0d_hold_busy_done", i), {o_busy, o_done}, 0);
            check($sformatf("vec%0d_hold_resp_err", i), {o_resp, o_err}, {vecs[i].resp, vecs[i].err});
            wait_idle();
        end

        // Randomized pairs against the oscillator-rate model.
        for (int r = 0; r < 8; r++) begin
            int a, b, ma, mb;
            a = $urandom_range(0, 7);
            b = $urandom_range(0, 6);
            if (b >= a) b = b + 1;
            ma = model_edges(HALF0[a]);
            mb = model_edges(HALF0[b]);
            run_one(0, 3'(a), 3'(b), 8'(1 << a) | 8'(1 << b), lat, en_ok, clr_ok);
            check($sformatf("rnd%0d_latency", r), lat, LAT);
            check($sformatf("rnd%0d_ro_en_clr", r), {en_ok, clr_ok}, 2'b11);
            check($sformatf("rnd%0d_err", r), o_err, 0);
            check_near($sformatf("rnd%0d_cnt_a", r), o_cnt_a, ma, 1);
            check_near($sformatf("rnd%0d_cnt_b", r), o_cnt_b, mb, 1);
            if (ma - mb >= 3 || mb - ma >= 3) begin
                check($sformatf("rnd%0d_resp", r), o_resp, (ma > mb) ? 1 : 0);
                check($sformatf("rnd%0d_tie", r), o_tie, 0);
            end
            wait_idle();
        end

        // Start pulsed mid-COUNT with another challenge, and again in the DONE cycle: both ignored.
        sel = 0;
        @(negedge clk);
        start = 1'b1; chal_a = 3'd2; chal_b = 3'd5;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (30) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b1; chal_a = 3'd3; chal_b = 3'd4;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!o_done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("midstart_latency", lat, LAT);
        check("midstart_resp", o_resp, 1);
        check_near("midstart_cnt_a", o_cnt_a, 16, 1);
        check_near("midstart_cnt_b", o_cnt_b, 8, 1);
        start = 1'b1; chal_a = 3'd3; chal_b = 3'd4;
        @(negedge clk);
        check("start_in_done_ignored", o_busy, 0);
        start = 1'b0;
        wait_idle();

        // Reset in the middle of COUNT.
        @(negedge clk);
        start = 1'b1; chal_a = 3'd2; chal_b = 3'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("pre_rst_ro_en", ro_en0, 8'b0010_0100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ro_en", ro_en0, 0);
        check("midrst_busy_done", {busy0, done0}, 0);
        check("midrst_flags", {resp0, tie0, err0}, 0);
        check("midrst_counts", {cnt_a0, cnt_b0}, 0);
        begin
            int seen;
            seen = 0;
            repeat (100) begin
                @(negedge clk);
                if (done0 || busy0) seen++;
            end
            check("midrst_no_done", seen, 0);
        end

        // A normal measurement after the reset.
        run_one(0, 3'd2, 3'd5, 8'b0010_0100, lat, en_ok, clr_ok);
        check("post_rst_latency", lat, LAT);
        check("post_rst_ro_en", en_ok, 1);
        check("post_rst_resp_tie_err", {o_resp, o_tie, o_err}, 3'b100);
        check_near("post_rst_cnt_a", o_cnt_a, 16, 1);
        check_near("post_rst_cnt_b", o_cnt_b, 8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_pair_comparator.md
Name: ro_pair_comparator

Overview:
- Measurement end of the ring-oscillator PUF.
- Takes the raw outputs of the RO bank and a challenge that names two oscillators.
- Enables only that pair, counts rising edges of each over a fixed window, and returns one response bit plus both counts.
- Sits between the RO bank and the key/response assembly logic. One challenge is in flight at a time.

Parameters:
- N_RO, 8, number of ring oscillators in the bank
- SEL_W, 3, challenge index width (clog2 of N_RO)
- CNT_W, 16, edge counter width
- WINDOW, 1024, count-window length in clk cycles (1 to 2^CNT_W)
- SETTLE, 8, clk cycles between enabling the pair and opening the window (2 or more)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ro_in  in  N_RO  raw RO outputs; asynchronous to clk, so always synchronized
- ro_en  out  N_RO  per-oscillator enable; one-hot pair during a measurement, else 0
- start  in  1  request; sampled only in IDLE
- chal_a  in  SEL_W  first RO index; latched on accept
- chal_b  in  SEL_W  second RO index; latched on accept
- busy  out  1  high from the cycle after accept through the DONE cycle
- done  out  1  one-cycle pulse when results become valid
- resp  out  1  1 if cnt_a > cnt_b, else 0
- tie  out  1  1 if cnt_a == cnt_b
- err  out  1  1 if chal_a == chal_b or either index >= N_RO
- cnt_a  out  CNT_W  edge count of oscillator chal_a
- cnt_b  out  CNT_W  edge count of oscillator chal_b

Behaviour:
- Clock and reset: single domain; clk is the clock and rst is a synchronous, active-high reset.
- Reset values: state=IDLE, ro_en=0, busy=0, done=0, resp=0, tie=0, err=0, cnt_a=0, cnt_b=0, all sync flops and counters 0.
- rst wins over everything, including mid-measurement. After rst, ro_en drops the next cycle and no done is produced.
- FSM states: IDLE, SETTLE, COUNT, DONE.
- IDLE, start=1, valid challenge: latch indices, clear internal counters, go to SETTLE. ro_en is set to bits a and b from the next cycle.
- IDLE, start=1, invalid challenge: go to DONE directly and set err=1. Results are then resp=0, tie=0, counts=0. No oscillator is enabled.
- SETTLE: lasts exactly SETTLE cycles; flushes the synchronizer pipeline. Edges are not counted. Then go to COUNT.
- COUNT: lasts exactly WINDOW cycles. On each cycle, a rising edge (prev=0, cur=1) on synchronized ro_in[a] or ro_in[b] increments its counter. Then go to DONE.
- DONE: one cycle.
  - ro_en=0, done=1, busy=1.
  - Registered outputs update this cycle: cnt_a/cnt_b, resp=(cnt_a>cnt_b), tie=(cnt_a==cnt_b), err.
  - Then go to IDLE.
- Latency: start accepted in cycle t gives done=1 in cycle t+1+SETTLE+WINDOW. An invalid challenge gives done in cycle t+1.
- Synchronizer: 2 flops per selected channel, plus one edge-detect flop.
- Counters saturate at 2^CNT_W-1; they never wrap.
- start while busy is ignored; start in the DONE cycle is ignored. A new start is accepted in IDLE on the cycle after DONE.
- chal_a/chal_b changes after accept have no effect.
- Result outputs hold until the next accepted start. They are cleared to 0 on accept.

Decomposition:
- Package puf_pkg holds:
  - the FSM state encoding (IDLE=0, SETTLE=1, COUNT=2, DONE=3)
  - default SYNC_STAGES=2
  - a localparam function for clog2
- Sub-module ro_edge_counter, instantiated twice:
  - ports: clk, rst, clr, en, ro_raw, cnt[CNT_W]
  - contains the synchronizer, edge detector and saturating counter
- The top-level holds the FSM, window/settle counter, index mux, validity check and comparator.

Test Plan:
- Bench setup: WINDOW=64, SETTLE=4. Behavioural RO models are gated by ro_en. ro_in[2] has period 4 clk and ro_in[5] has period 8 clk.
  - chal_a=2, chal_b=5, start pulse gives done exactly 69 cycles after accept.
  - Expected cnt_a=16±1, cnt_b=8±1, resp=1, tie=0, err=0.
  - ro_en must be 8'b0010_0100 only during SETTLE+COUNT.
- Swap to chal_a=5, chal_b=2 -> resp=0, tie=0, counts swapped.
- Same period on RO 3 and RO 4 (period 6, aligned phase), chal 3/4 -> cnt_a==cnt_b=10 or 11, tie=1, resp=0.
- Invalid challenges:
  - chal_a=chal_b=6 -> done in cycle t+1, err=1, ro_en never nonzero, counts 0.
  - Repeat with N_RO=6 and chal_b=7 -> err=1.
- CNT_W=4, RO period 2 over 64 cycles -> cnt saturates at 15, never wraps to a small value.
- Control robustness:
  - start pulsed again mid-COUNT, with chal changed -> ignored, results match the first challenge.
  - rst asserted mid-COUNT -> next cycle ro_en=0, busy=0, all outputs 0, no done.
  - A subsequent start completes normally.
